// File: rtl/thresholding_cfg_sequencer_pkg.sv
// Shared types and width helpers for the thresholding config sequencer.
// Field widths collapse to zero when a dimension is 1; counters keep at least one bit.
package thresholding_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY} state_e;

  function automatic int fw(input int n);
    return $clog2(n);
  endfunction

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cfg_addr_width(input int n, input int pe, input int cf);
    int w;
    w = fw(n) + fw(pe) + fw(cf);
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/thresholding_cfg_sequencer_if.sv
// Threshold stream, host readback and thresholding cfg port bundled together.
// master = sequencer side, slave = environment (source, host, thresholding core).
interface thresholding_cfg_sequencer_if #(
  parameter int K = 8,
  parameter int A = 1
);
  logic         s_tvalid, s_tready;
  logic [K-1:0] s_tdata;
  logic         rd_req, rd_rdy, rd_vld;
  logic [A-1:0] rd_addr;
  logic [K-1:0] rd_dat;
  logic         cfg_en, cfg_we, cfg_rack;
  logic [A-1:0] cfg_a;
  logic [K-1:0] cfg_d, cfg_q;

  modport master (
    input  s_tvalid, s_tdata, rd_req, rd_addr, cfg_rack, cfg_q,
    output s_tready, rd_rdy, rd_vld, rd_dat, cfg_en, cfg_we, cfg_a, cfg_d
  );
  modport slave (
    output s_tvalid, s_tdata, rd_req, rd_addr, cfg_rack, cfg_q,
    input  s_tready, rd_rdy, rd_vld, rd_dat, cfg_en, cfg_we, cfg_a, cfg_d
  );
endinterface

// File: rtl/thresholding_cfg_sequencer_addr_gen.sv
// Nested t/pe/cf counter producing the packed {cf,pe,t} cfg address.
// Shared by the load walk and the verify read-back walk.
module thresholding_cfg_addr_gen
  import thresholding_ctrl_pkg::*;
#(
  parameter int N = 1, PE = 1, CF = 1, A = 1
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [A-1:0] addr,
  output logic         last
);
  localparam int TW = fw(N), PW = fw(PE);
  localparam int TS = cw(N), PS = cw(PE), FS = cw(CF);

  logic [TS-1:0] t;
  logic [PS-1:0] pe;
  logic [FS-1:0] cf;
  logic t_end, pe_end, cf_end;

  assign t_end  = (t  == TS'(N - 1));
  assign pe_end = (pe == PS'(PE - 1));
  assign cf_end = (cf == FS'(CF - 1));
  assign last   = t_end && pe_end && cf_end;
  // shifting rather than concatenating keeps zero-width fields out of the address
  assign addr   = A'((32'(cf) << (PW + TW)) | (32'(pe) << TW) | 32'(t));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      t  <= '0;
      pe <= '0;
      cf <= '0;
    end else if (inc) begin
      if (!t_end) t <= t + 1'b1;
      else begin
        t <= '0;
        if (!pe_end) pe <= pe + 1'b1;
        else begin
          pe <= '0;
          cf <= cf_end ? '0 : cf + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/thresholding_cfg_sequencer.sv
// Owns the thresholding cfg port: streams in all C*N thresholds, serves host readback,
// gates the data path until a full set is resident. THRESHOLDING_CFG_VERIFY_EN adds a checksum read-back pass.
module thresholding_cfg_sequencer
  import thresholding_ctrl_pkg::*;
#(
  parameter int N = 1, K = 8, C = 1, PE = 1, OUTS = 4
)(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic verr,
  output logic stream_en,
  thresholding_cfg_sequencer_if.master cfg_bus
);
  localparam int CF = C / PE;
  localparam int A  = cfg_addr_width(N, PE, CF);

  state_e       state;
  logic         loaded;
  logic [3:0]   outst;
  logic         gen_inc, gen_last, word_acc, rd_issue, rack_ok, start_ok;
  logic [A-1:0] gen_addr;

  assign word_acc  = (state == LOAD) && cfg_bus.s_tvalid;
  assign rd_issue  = cfg_bus.rd_req && cfg_bus.rd_rdy;
  assign rack_ok   = cfg_bus.cfg_rack && (outst != 4'd0) && (state != VERIFY);
  assign start_ok  = start && (state == IDLE) && (outst == 4'd0);
  assign busy      = (state != IDLE);
  assign stream_en = loaded && (state == IDLE);
  assign cfg_bus.s_tready = (state == LOAD);
  // start wins the cycle so a read can never slip in alongside a reload
  assign cfg_bus.rd_rdy   = !rst && (state == IDLE) && !start && (outst < 4'(OUTS));

`ifdef THRESHOLDING_CFG_VERIFY_EN
  localparam int TOT = C * N;
  localparam int RW  = $clog2(TOT + 1);
  logic [K-1:0]  sum, vsum;
  logic          vissued, verr_q;
  logic [RW-1:0] rcnt;
  assign verr    = verr_q;
  assign gen_inc = word_acc || ((state == VERIFY) && !vissued);
`else
  assign verr    = 1'b0;
  assign gen_inc = word_acc;
`endif

  thresholding_cfg_addr_gen #(.N(N), .PE(PE), .CF(CF), .A(A)) u_addr_gen (
    .clk(clk), .rst(rst), .inc(gen_inc), .clr(start_ok), .addr(gen_addr), .last(gen_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      loaded         <= 1'b0;
      outst          <= 4'd0;
      done           <= 1'b0;
      cfg_bus.cfg_en <= 1'b0;
      cfg_bus.cfg_we <= 1'b0;
      cfg_bus.cfg_a  <= '0;
      cfg_bus.cfg_d  <= {K{1'b0}};
      cfg_bus.rd_vld <= 1'b0;
      cfg_bus.rd_dat <= {K{1'b0}};
`ifdef THRESHOLDING_CFG_VERIFY_EN
      sum     <= '0;
      vsum    <= '0;
      vissued <= 1'b0;
      verr_q  <= 1'b0;
      rcnt    <= '0;
`endif
    end else begin
      done           <= 1'b0;
      cfg_bus.cfg_en <= 1'b0;
      cfg_bus.cfg_we <= 1'b0;
      cfg_bus.rd_vld <= rack_ok;
      if (rack_ok) cfg_bus.rd_dat <= cfg_bus.cfg_q;
      outst <= outst + 4'(rd_issue) - 4'(rack_ok);
      case (state)
        IDLE: begin
          if (rd_issue) begin
            cfg_bus.cfg_en <= 1'b1;
            cfg_bus.cfg_a  <= cfg_bus.rd_addr;
          end
          if (start_ok) begin
            state  <= LOAD;
            loaded <= 1'b0;
`ifdef THRESHOLDING_CFG_VERIFY_EN
            sum    <= '0;
            verr_q <= 1'b0;
`endif
          end
        end
        LOAD: if (word_acc) begin
          cfg_bus.cfg_en <= 1'b1;
          cfg_bus.cfg_we <= 1'b1;
          cfg_bus.cfg_a  <= gen_addr;
          cfg_bus.cfg_d  <= cfg_bus.s_tdata;
`ifdef THRESHOLDING_CFG_VERIFY_EN
          sum <= sum + cfg_bus.s_tdata;
          if (gen_last) begin
            loaded  <= 1'b1;
            state   <= VERIFY;
            vissued <= 1'b0;
            vsum    <= '0;
            rcnt    <= '0;
          end
`else
          if (gen_last) begin
            loaded <= 1'b1;
            state  <= IDLE;
            done   <= 1'b1;
          end
`endif
        end
`ifdef THRESHOLDING_CFG_VERIFY_EN
        VERIFY: begin
          if (!vissued) begin
            cfg_bus.cfg_en <= 1'b1;
            cfg_bus.cfg_a  <= gen_addr;
            if (gen_last) vissued <= 1'b1;
          end
          if (cfg_bus.cfg_rack) begin
            vsum <= vsum + cfg_bus.cfg_q;
            rcnt <= rcnt + 1'b1;
            if (rcnt == RW'(TOT - 1)) begin
              state <= IDLE;
              done  <= 1'b1;
              if (K'(vsum + cfg_bus.cfg_q) != sum) verr_q <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_thresholding_cfg_sequencer.sv
// Randomized bench for thresholding_cfg_sequencer: two instances (3x8/PE4 and 1x1) against
// a behavioural thresholding-memory responder and a channel/threshold reference table.
module tb_thresholding_cfg_sequencer;
  localparam int K = 8, N = 3, C = 8, PE = 4, OUTS = 4, TOT = C * N;
  localparam int A = $clog2(N) + $clog2(PE) + $clog2(C / PE);

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0;
  logic busy, done, verr, stream_en, busy2, done2, verr2, stream_en2;
  int checks = 0, passes = 0, fails = 0;

  thresholding_cfg_sequencer_if #(.K(K), .A(A)) b1 ();
  thresholding_cfg_sequencer_if #(.K(K), .A(1)) b2 ();

  thresholding_cfg_sequencer #(.N(N), .K(K), .C(C), .PE(PE), .OUTS(OUTS)) u1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .verr(verr),
    .stream_en(stream_en), .cfg_bus(b1));
  thresholding_cfg_sequencer #(.N(1), .K(K), .C(1), .PE(1), .OUTS(OUTS)) u2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .verr(verr2),
    .stream_en(stream_en2), .cfg_bus(b2));

  always #5 clk = ~clk;

  // reference: channel c, threshold t lives at {c/PE, c%PE, t} with power-of-two field strides
  function automatic int ref_addr(input int c, input int t);
    return ((c / PE) << ($clog2(PE) + $clog2(N))) | ((c % PE) << $clog2(N)) | t;
  endfunction

  logic [K-1:0] words [TOT];
  logic [K-1:0] mem [32];
  int ncyc = 0, dueq[$], aq[$], wr_a[$], wr_d[$], rv[$], wr2_a[$], wr2_d[$];
  int done_cnt = 0, done2_cnt = 0;
  bit done_wr_ok = 1, done2_wr_ok = 1, inj_rack = 0, corrupt = 0;

  // thresholding memory model: writes land immediately, reads return 3 cycles later
  always @(negedge clk) begin
    ncyc++;
    if (b1.cfg_en && b1.cfg_we) begin
      mem[int'(b1.cfg_a)] = b1.cfg_d;
      wr_a.push_back(int'(b1.cfg_a));
      wr_d.push_back(int'(b1.cfg_d));
    end
    if (b1.cfg_en && !b1.cfg_we) begin
      dueq.push_back(ncyc + 3);
      aq.push_back(int'(b1.cfg_a));
    end
    b1.cfg_rack = 1'b0;
    b1.cfg_q    = '0;
    if (dueq.size() > 0 && dueq[0] == ncyc) begin
      void'(dueq.pop_front());
      b1.cfg_rack = 1'b1;
      b1.cfg_q    = mem[aq.pop_front()] ^ {{(K-1){1'b0}}, corrupt};
      corrupt     = 0;
    end else if (inj_rack) begin
      b1.cfg_rack = 1'b1;
      b1.cfg_q    = 8'h55;
      inj_rack    = 0;
    end
    if (b1.rd_vld) rv.push_back(int'(b1.rd_dat));
    if (done) begin
      done_cnt++;
      if (!(b1.cfg_en && b1.cfg_we)) done_wr_ok = 0;
    end
    b2.cfg_rack = 1'b0;
    b2.cfg_q    = '0;
    if (b2.cfg_en && b2.cfg_we) begin
      wr2_a.push_back(int'(b2.cfg_a));
      wr2_d.push_back(int'(b2.cfg_d));
    end
    if (done2) begin
      done2_cnt++;
      if (!(b2.cfg_en && b2.cfg_we)) done2_wr_ok = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_words();
    for (int i = 0; i < TOT; i++) words[i] = K'($urandom);
  endtask

  // starts a load on u1 and streams words with ~1 in 5 valid drops
  task automatic load1(input int start_at, input int rst_at, input bit hold_rd, output bit bad);
    int idx = 0, budget = 0;
    bad = 0;
    @(negedge clk); start = 1'b1; b1.rd_req = hold_rd; b1.rd_addr = '0;
    @(negedge clk); start = 1'b0;
    while (idx < TOT && budget < 500) begin
      budget++;
      if (hold_rd && (b1.rd_rdy || (b1.cfg_en && !b1.cfg_we))) bad = 1;
      if (idx == rst_at) begin
        rst = 1'b1;
        break;
      end
      b1.s_tvalid = ($urandom_range(4) != 0);
      b1.s_tdata  = words[idx];
      start = (idx == start_at);
      if (b1.s_tvalid && b1.s_tready) idx++;
      @(negedge clk);
    end
    b1.s_tvalid = 1'b0; b1.rd_req = 1'b0; start = 1'b0;
    chk("load_words_sent", idx, (rst_at >= 0) ? rst_at : TOT);
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy && b < 200) begin @(negedge clk); b++; end
    repeat (2) @(negedge clk);
    chk("wait_idle", busy, 0);
  endtask

  task automatic chk_contents(input string tag);
    int bad = 0;
    for (int c = 0; c < C; c++)
      for (int t = 0; t < N; t++)
        if (mem[ref_addr(c, t)] !== words[c * N + t]) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int d0, rc[6], rt[6], k, low_at, budget, nv;
    bit bad;
    b1.s_tvalid = 1'b0; b1.s_tdata = '0; b1.rd_req = 1'b0; b1.rd_addr = '0;
    b2.s_tvalid = 1'b0; b2.s_tdata = '0; b2.rd_req = 1'b0; b2.rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);          chk("rst_done", done, 0);
    chk("rst_stream_en", stream_en, 0); chk("rst_s_tready", b1.s_tready, 0);
    chk("rst_rd_rdy", b1.rd_rdy, 0);   chk("rst_cfg_en", b1.cfg_en, 0);
    chk("rst_rd_vld", b1.rd_vld, 0);   chk("rst_verr", verr, 0);
    chk("rst_cfg_a", b1.cfg_a, 0);     chk("rst_cfg_d", b1.cfg_d, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: full 24-word load, order and placement
    new_words();
    chk("pre_load_stream_en", stream_en, 0);
    load1(-1, -1, 0, bad);
    wait_idle();
    chk("t1_nwrites", wr_a.size(), TOT);
    for (int i = 0; i < TOT && i < wr_a.size(); i++) begin
      chk("t1_wr_addr", wr_a[i], ref_addr(i / N, i % N));
      chk("t1_wr_data", wr_d[i], words[i]);
    end
    chk("t1_addr3_is_4", wr_a[3], 4);
    chk("t1_last_addr_30", wr_a[TOT-1], 30);
    chk("t1_ch5_thr1_at21", mem[21], words[5 * N + 1]);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_stream_en", stream_en, 1);
    chk("t1_verr", verr, 0);
`ifndef THRESHOLDING_CFG_VERIFY_EN
    chk("t1_done_with_write", done_wr_ok, 1);
`endif

    // 2: degenerate 1x1 instance
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; b2.s_tvalid = 1'b1; b2.s_tdata = 8'h1A;
    budget = 0;
    while (!b2.s_tready && budget < 20) begin @(negedge clk); budget++; end
    @(negedge clk); b2.s_tvalid = 1'b0;
    repeat (12) @(negedge clk);
    chk("t2_nwrites", wr2_a.size(), 1);
    chk("t2_addr", wr2_a.size() > 0 ? wr2_a[0] : -1, 0);
    chk("t2_data", wr2_d.size() > 0 ? wr2_d[0] : -1, 8'h1A);
    chk("t2_done_once", done2_cnt, 1);
`ifndef THRESHOLDING_CFG_VERIFY_EN
    chk("t2_done_with_write", done2_wr_ok, 1);
`endif
    chk("t2_stream_en", stream_en2, 1);

    // 3: six back-to-back reads against OUTS=4
    for (int i = 0; i < 6; i++) begin rc[i] = $urandom_range(C - 1); rt[i] = $urandom_range(N - 1); end
    rv.delete();
    k = 0; low_at = -1; budget = 0;
    while (k < 6 && budget < 100) begin
      b1.rd_req = 1'b1; b1.rd_addr = A'(ref_addr(rc[k], rt[k]));
      if (!b1.rd_rdy && low_at < 0) low_at = k;
      if (b1.rd_rdy) k++;
      @(negedge clk); budget++;
    end
    b1.rd_req = 1'b0;
    chk("t3_all_issued", k, 6);
    chk("t3_rd_rdy_low_after_4", low_at, 4);
    budget = 0;
    while (rv.size() < 6 && budget < 50) begin @(negedge clk); budget++; end
    chk("t3_nvld", rv.size(), 6);
    for (int i = 0; i < 6 && i < rv.size(); i++) chk("t3_rd_dat", rv[i], words[rc[i] * N + rt[i]]);
    inj_rack = 1;
    repeat (4) @(negedge clk);
    chk("t3_spurious_rack_ignored", rv.size(), 6);

    // 4a: start during LOAD is dropped
    new_words(); d0 = done_cnt;
    load1(5, -1, 0, bad);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("t4_no_queued_start", busy, 0);
    chk("t4_done_once", done_cnt - d0, 1);
    chk_contents("t4_contents");

    // 4b: start with a read outstanding is dropped
    rv.delete();
    b1.rd_req = 1'b1; b1.rd_addr = '0;
    @(negedge clk); b1.rd_req = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("t4_outst_start_busy", busy, 0);
    chk("t4_outst_start_tready", b1.s_tready, 0);
    repeat (6) @(negedge clk);
    chk("t4_outst_read_vld", rv.size(), 1);
    chk("t4_outst_read_dat", rv.size() > 0 ? rv[0] : -1, words[0]);

    // 4c: reset at word 10 drops stream_en; 6: rd_req held during reload
    new_words();
    load1(-1, 10, 0, bad);
    repeat (2) @(negedge clk);
    chk("t4_rst_stream_en", stream_en, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_post_rst_stream_en", stream_en, 0);
    chk("t4_post_rst_busy", busy, 0);
    d0 = done_cnt;
    load1(-1, -1, 1, bad);
    chk("t6_no_read_during_load", bad, 0);
    wait_idle();
    chk("t4_reload_done", done_cnt - d0, 1);
    chk("t4_reload_stream_en", stream_en, 1);
    chk_contents("t4_reload_contents");

`ifdef THRESHOLDING_CFG_VERIFY_EN
    // 5: one corrupted read-back beat flags verr; a clean reload clears it
    new_words(); rv.delete(); corrupt = 1;
    load1(-1, -1, 0, bad);
    wait_idle();
    chk("t5_verr_set", verr, 1);
    chk("t5_no_rd_vld", rv.size(), 0);
    new_words();
    load1(-1, -1, 0, bad);
    wait_idle();
    chk("t5_verr_cleared", verr, 0);
    chk("t5_stream_en", stream_en, 1);
`else
    chk("t5_verr_tied", verr, 0);
`endif

    nv = fails;
    $display("%0d/%0d checks passed", passes, checks);
    if (nv < 0) $display("unreachable");
    $finish;
  end
endmodule
